icache: RTL
===========

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache; responder side of the fetch request interface.
//  Accepts one word request per addr_ready pulse and returns the word with a one-cycle cache_ack pulse.
//  On a miss it refills a whole line from backing memory over a simple req/ack word interface.
//  Sits between the fetch stage and instruction memory; handles at most one outstanding request.
// PARAMETERS
//  LINES           16  number of cache lines (power of 2)
//  WORDS_PER_LINE  4   32-bit words per line (power of 2, >=2)
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  addr_ready in   1   fetch request strobe, one cycle
//  addr       in   32  request byte address, sampled when addr_ready=1; addr[1:0] ignored
//  flush      in   1   invalidate all lines (fence.i)
//  cache_ack  out  1   one-cycle pulse, inst valid
//  inst       out  32  requested word when cache_ack=1, else 32'h00000013 (nop)
//  mem_req    out  1   word read request to memory, held until mem_ack
//  mem_addr   out  32  word-aligned byte address of mem_req
//  mem_ack    in   1   memory returns mem_rdata this cycle
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Address split: word = addr[2 +: OW], OW=log2(WORDS_PER_LINE); index = next log2(LINES) bits; tag = rest.
//  Storage: per line valid bit, tag, data words; all flops, combinational read.
//  Reset: state IDLE, all valid=0, cache_ack=0, inst=nop, mem_req=0, mem_addr=0, flush_pend=0.
//  States:
//   IDLE: addr_ready=1 -> latch addr into req_q, go LOOKUP. Otherwise stay.
//   LOOKUP: valid[idx] && tag match -> cache_ack=1, inst=data[idx][word], go IDLE (hit latency: ack in cycle after addr_ready).
//           miss -> beat=0, valid[idx]=0, go REFILL.
//   REFILL: mem_req=1, mem_addr={tag,idx,beat,2'b00}. On mem_ack: write mem_rdata to data[idx][beat];
//           capture it if beat==word; beat==WORDS_PER_LINE-1 -> write tag, valid[idx]=1, go RESPOND; else beat++.
//           mem_addr advances the cycle after each mem_ack; mem_req stays high between beats.
//           mem_ack in first cycle of mem_req is legal.
//   RESPOND: cache_ack=1, inst=captured word, go IDLE.
//  cache_ack never asserted in the same cycle as the addr_ready that created the request; exactly one ack per accepted request.
//  Request accepted in IDLE the cycle after an ack (back-to-back hits at one request per two cycles).
//  addr_ready outside IDLE: ignored, no ack (protocol violation; fetch never issues it).
//  flush: in IDLE clears all valid bits that cycle; elsewhere sets flush_pend, applied on next IDLE cycle.
//   Refill in progress completes and acks normally; its line is then invalidated by the pending flush.
//   addr_ready with flush in IDLE: request accepted, lookup sees cleared valids (miss).
//  rst mid-refill: all state to reset values next cycle; partial line left invalid; no ack for old request.
//  mem_rdata ignored when mem_ack=0 or mem_req=0.
// TESTING
//  1 Cold: rst, addr_ready addr=0x0 -> mem_addr 0x0,0x4,0x8,0xC; one ack, inst=mem[0x0]; then addr=0x4 -> ack next cycle, mem_req stays 0.
//  2 Mid-line miss: addr=0x28, mem_ack latency 3 -> mem_addr 0x20..0x2C, inst=mem[0x28], single ack after last beat.
//  3 Conflict: 0x000 (fill), 0x100 (same index, new tag) -> miss and refill; 0x000 again -> miss.
//  4 Back-to-back: hit, addr_ready in cycle after ack -> accepted; ack 2 cycles after previous ack; nop on inst between acks.
//  5 flush during REFILL of 0x40 -> ack delivered with mem[0x40]; next request 0x40 misses.
//  6 rst in beat 2 of refill -> mem_req=0, cache_ack=0 next cycle; request to same line misses and refills all 4 words.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with whole-line refill from word-wide backing memory.
// Serves one outstanding fetch request at a time; hits acknowledge the cycle after the request.
module icache #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ready,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        cache_ack,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - OW - IW;
  localparam logic [OW-1:0] LastBeat = OW'(WORDS_PER_LINE - 1);
  localparam logic [31:0]   Nop      = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StLookup, StRefill, StRespond} state_e;

  state_e        state_q, state_d;
  logic [29:0]   req_q;
  logic [OW-1:0] beat_q;
  logic [31:0]   word_q;
  logic          flush_pend_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q  [LINES];
  logic [31:0]   data_q [LINES][WORDS_PER_LINE];

  logic [OW-1:0] req_word;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          unused_addr;

  // Byte offset bits are never used for word fetches.
  assign unused_addr = ^addr[1:0];

  assign req_word = req_q[0 +: OW];
  assign req_idx  = req_q[OW +: IW];
  assign req_tag  = req_q[29 -: TW];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d   = state_q;
    cache_ack = 1'b0;
    inst      = Nop;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (addr_ready) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          cache_ack = 1'b1;
          inst      = data_q[req_idx][req_word];
          state_d   = StIdle;
        end else begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q, 2'b00};
        if (mem_ack && (beat_q == LastBeat)) state_d = StRespond;
      end
      StRespond: begin
        cache_ack = 1'b1;
        inst      = word_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= '0;
      beat_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (addr_ready) req_q <= addr[31:2];
        end
        StLookup: begin
          if (!hit) begin
            beat_q           <= '0;
            valid_q[req_idx] <= 1'b0;
          end
        end
        StRefill: begin
          if (mem_ack) begin
            if (beat_q == req_word) word_q <= mem_rdata;
            if (beat_q == LastBeat) valid_q[req_idx] <= 1'b1;
            else                    beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
      // Flush only takes effect in IDLE so an in-flight refill still completes and acks.
      if (state_q == StIdle) begin
        if (flush || flush_pend_q) valid_q <= '0;
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == StRefill) && mem_ack) begin
      data_q[req_idx][beat_q] <= mem_rdata;
      if (beat_q == LastBeat) tag_q[req_idx] <= req_tag;
    end
  end

endmodule
